// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the fetch PC and a circular return-address stack.
// Resolves return/branch/call redirects from decode and emits a one-cycle flush pulse.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 32,
    parameter int                     RAS_DEPTH    = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          take_branch_target,
    input  logic [PC_WIDTH-1:0]           branch_target,
    input  logic [PC_WIDTH-1:0]           decode_pc,
    input  logic                          is_call,
    input  logic                          is_return,
    output logic [PC_WIDTH-1:0]           pc,
    output logic                          flush,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                flush_q, flush_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                push_en;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [PTR_W-1:0]    top_ptr;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] link_addr;

    assign top_ptr   = ptr_q - PTR_W'(1);
    assign pc_seq    = pc_q + PC_STEP;
    assign link_addr = decode_pc + PC_STEP;

    always_comb begin
        pc_d    = pc_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            if (is_return && (cnt_q != '0)) begin
                pc_d    = ras_q[top_ptr];
                ptr_d   = top_ptr;
                cnt_d   = cnt_q - CNT_W'(1);
                flush_d = 1'b1;
            end else if (is_return) begin
                pc_d  = pc_seq;
                unf_d = 1'b1;
            end else if (take_branch_target) begin
                pc_d    = branch_target;
                flush_d = 1'b1;
                if (is_call) begin
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                    // A push into a full stack silently overwrites the oldest entry.
                    if (cnt_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage is data only; emptiness is tracked by cnt_q, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push_en && !reset) begin
            ras_q[ptr_q] <= link_addr;
        end
    end

    assign pc            = pc_q;
    assign flush         = flush_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
